// File: rtl/riscv_bitops_seq.sv
// Multi-cycle BITCOUNT/REVERSE unit beside the ALU. Consumes CHUNK_W bits per cycle, so the result is valid N+1 cycles after accept.
// busy_o stalls ID/EX while slicing; a DONE result is held until ex_ready_i, and kill_i aborts from any state.
module riscv_bitops_seq #(
    parameter int DATA_W       = 32,
    parameter int CHUNK_W      = 8,
    parameter int BIT_OP_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [BIT_OP_WIDTH-1:0] operator_i,
    input  logic [DATA_W-1:0]       operand_i,
    input  logic                    kill_i,
    input  logic                    ex_ready_i,
    output logic                    ready_o,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic [DATA_W-1:0]       result_o
);
    localparam int N     = DATA_W / CHUNK_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BIT_OP_WIDTH-1:0] BIT_OP_BITCOUNT = BIT_OP_WIDTH'(0);
    localparam logic [BIT_OP_WIDTH-1:0] BIT_OP_REVERSE  = BIT_OP_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       sr_q, sr_d;
    logic [DATA_W-1:0]       acc_q, acc_d;
    logic [DATA_W-1:0]       res_q, res_d;
    logic [BIT_OP_WIDTH-1:0] op_q, op_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CHUNK_W-1:0]      chunk;
    logic                    accept;

    function automatic logic [DATA_W-1:0] popcount(input logic [CHUNK_W-1:0] c);
        logic [DATA_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_W; i++) n = n + DATA_W'(c[i]);
        return n;
    endfunction

    function automatic logic [CHUNK_W-1:0] bitrev(input logic [CHUNK_W-1:0] c);
        logic [CHUNK_W-1:0] r;
        for (int i = 0; i < CHUNK_W; i++) r[i] = c[CHUNK_W-1-i];
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        chunk   = sr_q[CHUNK_W-1:0];

        ready_o = ((state_q == S_IDLE) || (state_q == S_DONE && ex_ready_i)) && !kill_i;
        accept  = enable_i && ready_o;

        if (kill_i) begin
            // Abort drops the op but leaves sr/acc alone; the next accept reloads them.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_BUSY: begin
                    sr_d  = sr_q >> CHUNK_W;
                    cnt_d = cnt_q + 1'b1;
                    case (op_q)
                        BIT_OP_BITCOUNT: acc_d = acc_q + popcount(chunk);
                        BIT_OP_REVERSE:  acc_d = (acc_q << CHUNK_W) | DATA_W'(bitrev(chunk));
                        default:         acc_d = '0;
                    endcase
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = S_DONE;
                        res_d   = acc_d;
                    end
                end
                S_DONE: if (ex_ready_i) state_d = S_IDLE;
                default: ;
            endcase
            if (accept) begin
                state_d = S_BUSY;
                sr_d    = operand_i;
                op_d    = operator_i;
                acc_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o   = (state_q == S_BUSY);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = res_q;
endmodule

// File: tb/tb_riscv_bitops_seq.sv
// Directed bench for riscv_bitops_seq: three instances (CHUNK_W 8, 1, 32) share one stimulus bus.
module tb_riscv_bitops_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  operator;
    logic [31:0] operand;
    logic        kill;
    logic        ex_ready;
    logic        ready_w [3];
    logic        busy_w  [3];
    logic        valid_w [3];
    logic [31:0] res_w   [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_bitops_seq #(.DATA_W(32), .CHUNK_W(8), .BIT_OP_WIDTH(2)) u_c8 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(operator), .operand_i(operand),
        .kill_i(kill), .ex_ready_i(ex_ready), .ready_o(ready_w[0]), .busy_o(busy_w[0]),
        .valid_o(valid_w[0]), .result_o(res_w[0]));
    riscv_bitops_seq #(.DATA_W(32), .CHUNK_W(1), .BIT_OP_WIDTH(2)) u_c1 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(operator), .operand_i(operand),
        .kill_i(kill), .ex_ready_i(ex_ready), .ready_o(ready_w[1]), .busy_o(busy_w[1]),
        .valid_o(valid_w[1]), .result_o(res_w[1]));
    riscv_bitops_seq #(.DATA_W(32), .CHUNK_W(32), .BIT_OP_WIDTH(2)) u_c32 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(operator), .operand_i(operand),
        .kill_i(kill), .ex_ready_i(ex_ready), .ready_o(ready_w[2]), .busy_o(busy_w[2]),
        .valid_o(valid_w[2]), .result_o(res_w[2]));

    // Waits (bounded) until every instance can accept a request.
    task automatic wait_all_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = ready_w[0] && ready_w[1] && ready_w[2];
        end
    endtask

    // Issues one op and records busy cycles, cycles until valid, and the delivered result of one instance.
    task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                          output int busy_n, output int cyc_n, output logic [31:0] res, output bit got);
        bit ok;
        busy_n = 0; cyc_n = 0; res = '0; got = 1'b0;
        wait_all_ready(ok);
        if (ok) begin
            @(posedge clk) #1;
            enable = 1'b1; operator = op; operand = a;
            @(posedge clk) #1;
            enable = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                cyc_n++;
                if (busy_w[sel]) busy_n++;
                if (valid_w[sel]) begin
                    got = 1'b1;
                    res = res_w[sel];
                end
            end
        end
    endtask

    task automatic test_reset;
        int b, c; logic [31:0] r; bit g;
        n_cmp++; if (ready_w[0] !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_w[0]); end
        n_cmp++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_w[0]); end
        n_cmp++; if (valid_w[0] !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_w[0]); end
        n_cmp++; if (res_w[0] !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", res_w[0]); end
        @(posedge clk) #1; rst_n = 1'b1;
        // Leave a nonzero result behind, then reset in the middle of the next op.
        run_op(0, 2'b01, 32'h0000_0001, b, c, r, g);
        n_cmp++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL prereset_result: got %h want 80000000", r); end
        @(posedge clk) #1; enable = 1'b1; operator = 2'b00; operand = 32'hFFFF_FFFF;
        @(posedge clk) #1; enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy_w[0] !== 1'b1) begin n_err++; $display("FAIL midop_busy: got %b want 1", busy_w[0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", busy_w[0]); end
        n_cmp++; if (valid_w[0] !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", valid_w[0]); end
        n_cmp++; if (ready_w[0] !== 1'b1) begin n_err++; $display("FAIL async_ready: got %b want 1", ready_w[0]); end
        n_cmp++; if (res_w[0] !== 32'h0) begin n_err++; $display("FAIL async_result: got %h want 0", res_w[0]); end
        @(posedge clk) #1; rst_n = 1'b1;
    endtask

    task automatic test_bitcount;
        logic [31:0] vin [3] = '{32'hF0F0_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [31:0] vexp[3] = '{32'd9, 32'd32, 32'd0};
        int b, c; logic [31:0] r; bit g;
        for (int k = 0; k < 3; k++) begin
            run_op(0, 2'b00, vin[k], b, c, r, g);
            n_cmp++; if (!g || r !== vexp[k]) begin n_err++; $display("FAIL bitcount_%0d: got %h (valid seen %0d) want %h", k, r, g, vexp[k]); end
            n_cmp++; if (b != 4 || c != 5) begin n_err++; $display("FAIL bitcount_lat_%0d: busy %0d valid@%0d want busy 4 valid@5", k, b, c); end
        end
    endtask

    task automatic test_reverse;
        logic [31:0] vin [2] = '{32'h0000_0001, 32'h1234_5678};
        logic [31:0] vexp[2] = '{32'h8000_0000, 32'h1E6A_2C48};
        int b, c; logic [31:0] r; bit g;
        for (int k = 0; k < 2; k++) begin
            run_op(0, 2'b01, vin[k], b, c, r, g);
            n_cmp++; if (!g || r !== vexp[k]) begin n_err++; $display("FAIL reverse_%0d: got %h want %h", k, r, vexp[k]); end
            n_cmp++; if (b != 4 || c != 5) begin n_err++; $display("FAIL reverse_lat_%0d: busy %0d valid@%0d want busy 4 valid@5", k, b, c); end
        end
    endtask

    task automatic test_chunk_widths;
        int b, c; logic [31:0] r; bit g;
        run_op(1, 2'b01, 32'h1234_5678, b, c, r, g);
        n_cmp++; if (!g || r !== 32'h1E6A_2C48) begin n_err++; $display("FAIL c1_reverse: got %h want 1e6a2c48", r); end
        n_cmp++; if (b != 32 || c != 33) begin n_err++; $display("FAIL c1_lat: busy %0d valid@%0d want busy 32 valid@33", b, c); end
        run_op(2, 2'b01, 32'h1234_5678, b, c, r, g);
        n_cmp++; if (!g || r !== 32'h1E6A_2C48) begin n_err++; $display("FAIL c32_reverse: got %h want 1e6a2c48", r); end
        n_cmp++; if (b != 1 || c != 2) begin n_err++; $display("FAIL c32_lat: busy %0d valid@%0d want busy 1 valid@2", b, c); end
        run_op(2, 2'b00, 32'hF0F0_0001, b, c, r, g);
        n_cmp++; if (!g || r !== 32'd9) begin n_err++; $display("FAIL c32_bitcount: got %h want 9", r); end
        run_op(1, 2'b00, 32'h8000_0001, b, c, r, g);
        n_cmp++; if (!g || r !== 32'd2) begin n_err++; $display("FAIL c1_bitcount: got %h want 2", r); end
    endtask

    task automatic test_back_to_back;
        bit ok, got;
        int b, c; logic [31:0] r; bit g;
        wait_all_ready(ok);
        ex_ready = 1'b0;
        @(posedge clk) #1; enable = 1'b1; operator = 2'b00; operand = 32'hFFFF_FFFF;
        @(posedge clk) #1; enable = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = valid_w[0];
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL bp_valid_timeout: valid %b want 1", valid_w[0]); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (valid_w[0] !== 1'b1 || res_w[0] !== 32'd32) begin
                n_err++; $display("FAIL bp_hold_%0d: valid %b result %h want 1 / 00000020", i, valid_w[0], res_w[0]);
            end
        end
        @(posedge clk) #1; ex_ready = 1'b1; enable = 1'b1; operator = 2'b01; operand = 32'h0000_0001;
        @(negedge clk);
        n_cmp++; if (ready_w[0] !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", ready_w[0]); end
        @(posedge clk) #1; enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy_w[0] !== 1'b1 || valid_w[0] !== 1'b0) begin
            n_err++; $display("FAIL b2b_no_bubble: busy %b valid %b want 1 / 0", busy_w[0], valid_w[0]);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = valid_w[0];
        end
        n_cmp++; if (!got || res_w[0] !== 32'h8000_0000) begin n_err++; $display("FAIL b2b_result: got %h want 80000000", res_w[0]); end
        run_op(0, 2'b00, 32'h0000_0003, b, c, r, g);
        n_cmp++; if (!g || r !== 32'd2) begin n_err++; $display("FAIL after_b2b: got %h want 2", r); end
    endtask

    task automatic test_kill;
        int b, c, vseen; logic [31:0] r; bit g, ok;
        run_op(0, 2'b01, 32'h1234_5678, b, c, r, g);
        wait_all_ready(ok);
        @(posedge clk) #1; enable = 1'b1; operator = 2'b00; operand = 32'hFFFF_FFFF;
        @(posedge clk) #1; enable = 1'b0;
        @(posedge clk) #1; kill = 1'b1;
        @(negedge clk);
        n_cmp++; if (ready_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_err++; $display("FAIL kill_cycle: ready %b busy %b want 0 / 1", ready_w[0], busy_w[0]);
        end
        @(posedge clk) #1; kill = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
            n_err++; $display("FAIL kill_idle: busy %b ready %b want 0 / 1", busy_w[0], ready_w[0]);
        end
        vseen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_w[0]) vseen++;
        end
        n_cmp++; if (vseen != 0) begin n_err++; $display("FAIL kill_no_valid: saw valid %0d cycles want 0", vseen); end
        n_cmp++; if (res_w[0] !== 32'h1E6A_2C48) begin n_err++; $display("FAIL kill_result_hold: got %h want 1e6a2c48", res_w[0]); end
        run_op(0, 2'b01, 32'h0000_0001, b, c, r, g);
        n_cmp++; if (!g || r !== 32'h8000_0000) begin n_err++; $display("FAIL kill_then_reverse: got %h want 80000000", r); end
    endtask

    task automatic test_illegal_op;
        int b, c, bseen; logic [31:0] r; bit g, ok;
        run_op(0, 2'b10, 32'hFFFF_FFFF, b, c, r, g);
        n_cmp++; if (!g || r !== 32'h0) begin n_err++; $display("FAIL illegal_result: got %h want 0", r); end
        n_cmp++; if (b != 4 || c != 5) begin n_err++; $display("FAIL illegal_lat: busy %0d valid@%0d want busy 4 valid@5", b, c); end
        wait_all_ready(ok);
        @(posedge clk) #1; enable = 1'b1; kill = 1'b1; operator = 2'b00; operand = 32'hFFFF_FFFF;
        @(posedge clk) #1; enable = 1'b0; kill = 1'b0;
        bseen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy_w[0] || valid_w[0]) bseen++;
        end
        n_cmp++; if (bseen != 0) begin n_err++; $display("FAIL kill_enable_idle: busy/valid seen %0d cycles want 0", bseen); end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; operator = 2'b00; operand = '0; kill = 1'b0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_bitcount();
        test_reverse();
        test_chunk_widths();
        test_back_to_back();
        test_kill();
        test_illegal_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
